// File: rtl/gpu_pkg.sv
// Package gpu: shared types and default constants for the pixel write path.
//   pixel_write_t : one buffered pixel write (32-bit byte address, 16-bit colour)
//   pwb_state_t   : pixel_write_buffer controller states
//   PWB_DEPTH     : default buffer depth (entries)
//   PWB_TIMEOUT   : default stall limit (consecutive stalled cycles)
package gpu;

    typedef struct packed {
        logic [31:0] address;
        logic [15:0] colour;
    } pixel_write_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FAULT = 2'd2
    } pwb_state_t;

    localparam int PWB_DEPTH   = 8;
    localparam int PWB_TIMEOUT = 1024;

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO of pixel_write_t entries.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   flush          : synchronous empty (priority over push/pop)
//   push/push_data : write an entry (ignored when full)
//   pop            : drop the head entry (ignored when empty)
//   head           : current head entry, valid while !empty
//   full/empty     : occupancy flags
//   count          : entries currently held
module pixel_fifo
    import gpu::*;
#(
    parameter int DEPTH = PWB_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  pixel_write_t               push_data,
    input  logic                       pop,
    output pixel_write_t               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    pixel_write_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clock) begin
        if (do_push && !reset && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pixel_write_buffer.sv
// pixel_write_buffer: buffers shader pixel writes and drains them to an
// Avalon-MM write master, one write per cycle when the slave does not stall.
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  : shader write handshake
//   in_address/in_data : halfword-aligned byte address and pixel colour
//   m1_*               : Avalon-MM master write port
//   count              : entries currently buffered
//   idle               : buffer empty and controller idle
//   error/clear_error  : sticky fault flag and its clear
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | nothing buffered, no write on m1
// ST_BUSY  | entries buffered, head presented on m1
// ST_FAULT | misaligned push or stall timeout; buffer flushed, waits clear_error
module pixel_write_buffer
    import gpu::*;
#(
    parameter int DEPTH   = PWB_DEPTH,
    parameter int TIMEOUT = PWB_TIMEOUT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_address,
    input  logic [15:0]                in_data,
    output logic [31:0]                m1_address,
    output logic [15:0]                m1_writedata,
    output logic                       m1_write,
    input  logic                       m1_waitrequest,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       idle,
    output logic                       error,
    input  logic                       clear_error
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(TIMEOUT+1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT-1);

    pwb_state_t    state;
    logic [SW-1:0] stall_cnt;
    logic          full;
    logic          empty;
    logic [CW-1:0] fifo_count;
    pixel_write_t  head;
    pixel_write_t  push_word;
    logic          accept;
    logic          misaligned;
    logic          do_push;
    logic          do_pop;
    logic          stalled;
    logic          timeout_hit;
    logic          fault_now;
    logic          flush;

    assign accept      = in_valid && in_ready;
    assign misaligned  = accept && in_address[0];
    assign do_push     = accept && !in_address[0];
    assign do_pop      = m1_write && !m1_waitrequest;
    assign stalled     = m1_write && m1_waitrequest;
    assign timeout_hit = stalled && (stall_cnt == STALL_LAST);
    assign fault_now   = misaligned || timeout_hit;
    // Flush on the faulting edge itself so count reads 0 throughout FAULT.
    assign flush       = (state == ST_FAULT) || fault_now;
    assign push_word   = '{address: in_address, colour: in_data};

    pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (do_push),
        .push_data (push_word),
        .pop       (do_pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // Outputs derive only from registered state, never from m1_waitrequest.
    assign in_ready     = !full && (state != ST_FAULT);
    assign m1_write     = (state == ST_BUSY) && !empty;
    assign m1_address   = head.address;
    assign m1_writedata = head.colour;
    assign count        = fifo_count;
    assign idle         = (fifo_count == '0) && (state == ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            error     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            stall_cnt <= (stalled && !timeout_hit) ? stall_cnt + SW'(1) : '0;
            case (state)
                ST_FAULT: begin
                    if (clear_error) begin
                        state <= ST_IDLE;
                        error <= 1'b0;
                    end
                end
                default: begin
                    if (fault_now) begin
                        state <= ST_FAULT;
                        error <= 1'b1;
                    end else if (state == ST_IDLE && do_push) begin
                        state <= ST_BUSY;
                    end else if (state == ST_BUSY && do_pop && !do_push &&
                                 fifo_count == CW'(1)) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_write_buffer.sv
module tb_pixel_write_buffer;
    import gpu::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_address;
    logic [15:0] in_data;
    logic [31:0] m1_address;
    logic [15:0] m1_writedata;
    logic        m1_write;
    logic        m1_waitrequest;
    logic [3:0]  count;
    logic        idle;
    logic        error;
    logic        clear_error;

    int checks   = 0;
    int failures = 0;

    pixel_write_t exp_q[$];

    pixel_write_buffer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_address     (in_address),
        .in_data        (in_data),
        .m1_address     (m1_address),
        .m1_writedata   (m1_writedata),
        .m1_write       (m1_write),
        .m1_waitrequest (m1_waitrequest),
        .count          (count),
        .idle           (idle),
        .error          (error),
        .clear_error    (clear_error)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus #1 after an edge, log accepted pushes,
    // then advance to #1 after the next edge.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [15:0] d,
                         input logic w);
        in_valid       = v;
        in_address     = a;
        in_data        = d;
        m1_waitrequest = w;
        #0;
        if (v && in_ready && !a[0] && !reset && !clear_error)
            exp_q.push_back('{address: a, colour: d});
        @(posedge clock);
        #1;
    endtask

    // Monitor: each accepted m1 write must match the oldest expected entry,
    // and stalled outputs must hold until accepted.
    logic        prev_stall = 1'b0;
    logic [47:0] prev_word  = '0;
    always @(negedge clock) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && !error)
                chk("hold", {15'd0, m1_write, m1_address, m1_writedata},
                    {15'd0, 1'b1, prev_word});
            if (m1_write && !m1_waitrequest) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {16'd0, m1_address, m1_writedata}, 64'd0);
                end else begin
                    chk("write_order", {16'd0, m1_address, m1_writedata},
                        {16'd0, exp_q[0].address, exp_q[0].colour});
                    void'(exp_q.pop_front());
                end
            end
            prev_stall <= m1_write && m1_waitrequest;
            prev_word  <= {m1_address, m1_writedata};
        end
    end

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; in_address = '0; in_data = '0;
        m1_waitrequest = 1'b0; clear_error = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_m1_write", m1_write, 0);
        chk("rst_count", count, 0);
        chk("rst_idle", idle, 1);
        chk("rst_error", error, 0);

        // Single write, latency 1, idle one cycle after the write.
        cycle(1, 32'h0800_0000, 16'h1111, 0);
        chk("lat_m1_write", m1_write, 1);
        chk("lat_address", m1_address, 32'h0800_0000);
        chk("lat_data", m1_writedata, 16'h1111);
        chk("lat_idle_busy", idle, 0);
        cycle(0, 0, 0, 0);
        chk("lat_idle_after", idle, 1);

        // Fill under stall, then drain back to back.
        for (int i = 0; i < DEPTH; i++)
            cycle(1, 32'h0800_1000 + 32'(i*2), 16'hA000 + 16'(i), 1);
        chk("full_count", count, DEPTH);
        chk("full_in_ready", in_ready, 0);
        cycle(1, 32'h0800_2000, 16'hDEAD, 1);
        chk("full_reject_count", count, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_m1_write", m1_write, 1);
            cycle(0, 0, 0, 0);
            if (i == 0) chk("full_pop_in_ready", in_ready, 1);
        end
        chk("drain_count", count, 0);
        chk("drain_idle", idle, 1);
        chk("drain_q_empty", exp_q.size(), 0);

        // Continuous push while waitrequest toggles every cycle.
        for (int i = 0; i < 20; i++) begin
            cycle(1, 32'h0801_0000 + 32'(i*2), 16'h5000 + 16'(i), i[0]);
            chk("toggle_count_le_depth", 64'(count <= DEPTH), 1);
        end
        n = 0;
        while (m1_write && n < 20) begin
            cycle(0, 0, 0, 0);
            n++;
        end
        chk("toggle_drained", m1_write, 0);
        chk("toggle_q_empty", exp_q.size(), 0);

        // Misaligned push.
        cycle(1, 32'h0800_0001, 16'hBEEF, 0);
        chk("mis_error", error, 1);
        chk("mis_in_ready", in_ready, 0);
        chk("mis_count", count, 0);
        chk("mis_m1_write", m1_write, 0);
        clear_error = 1'b1;
        cycle(0, 0, 0, 0);
        clear_error = 1'b0;
        chk("mis_clr_error", error, 0);
        chk("mis_clr_idle", idle, 1);

        // Stall timeout.
        cycle(1, 32'h0802_0000, 16'h7777, 1);
        for (int i = 1; i <= TIMEOUT; i++) begin
            cycle(0, 0, 0, 1);
            if (i == TIMEOUT - 1) chk("to_not_yet", error, 0);
        end
        chk("to_error", error, 1);
        chk("to_m1_write", m1_write, 0);
        chk("to_count", count, 0);
        exp_q.delete();
        clear_error = 1'b1;
        cycle(0, 0, 0, 0);
        clear_error = 1'b0;
        chk("to_clr_idle", idle, 1);
        chk("to_clr_error", error, 0);

        // Reset with three stalled entries.
        for (int i = 0; i < 3; i++)
            cycle(1, 32'h0803_0000 + 32'(i*2), 16'h3000 + 16'(i), 1);
        chk("rst3_count_before", count, 3);
        reset = 1'b1;
        cycle(0, 0, 0, 1);
        reset = 1'b0;
        exp_q.delete();
        chk("rst3_m1_write", m1_write, 0);
        chk("rst3_count", count, 0);
        chk("rst3_in_ready", in_ready, 1);
        cycle(0, 0, 0, 0);
        chk("rst3_idle", idle, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
